// File: rtl/insn_encoder_pkg.sv
// Shared opcode definitions for the instruction encoder slice.
//
// Package arm_pkg holds:
//   op_e      - 4-bit request operation code (codes 11..15 are illegal)
//   OPC_*     - fixed opcode field constants for each instruction format.
//               The control decoder imports the same constants, so the two
//               sides cannot drift apart.
//   state_e   - encoder FSM states
package arm_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_ORR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_MOVZ = 4'd6,
    OP_B    = 4'd7,
    OP_CBZ  = 4'd8,
    OP_LDUR = 4'd9,
    OP_STUR = 4'd10
  } op_e;

  // R-format, bits [31:21]
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  // I-format, bits [31:22]
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  // IW-format, bits [31:23]
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
  // B-format, bits [31:26]
  localparam logic [5:0]  OPC_B    = 6'b000101;
  // CB-format, bits [31:24]
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  // D-format, bits [31:21]
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/insn_encoder_if.sv
// Request / instruction-memory bus of the instruction encoder.
//
// Signals:
//   req_valid, req_ready      - encode request handshake
//   req_op, req_rd/rn/rm      - operation and register fields
//   req_imm, req_hw           - immediate (26 bits) and MOVZ shift field
//   base_load, base_addr      - reload of the write pointer
//   imem_we/addr/wdata        - instruction-memory write port
//   imem_ack                  - memory accepted the presented write
//   err                       - one-cycle pulse on a rejected request
//   count                     - number of acknowledged writes
// Modports: master = request/memory side, slave = encoder.
interface insn_encoder_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rn;
  logic [4:0]        req_rm;
  logic [25:0]       req_imm;
  logic [1:0]        req_hw;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;
  logic              err;
  logic [ADDR_W-1:0] count;

  modport master (
    output req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_hw,
           base_load, base_addr, imem_ack,
    input  req_ready, imem_we, imem_addr, imem_wdata, err, count
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_hw,
           base_load, base_addr, imem_ack,
    output req_ready, imem_we, imem_addr, imem_wdata, err, count
  );
endinterface

// File: rtl/insn_encoder_pack.sv
// insn_field_pack: purely combinational packing of request fields into a
// 32-bit instruction word.
//
// Ports:
//   op, rd, rn, rm, imm, hw  - request fields (in)
//   word                     - packed instruction (out)
//   legal                    - op is one of the defined operation codes (out)
//   range_ok                 - immediate fits its field (out)
//
// Build option INSN_ENCODER_RANGECHK_EN: when defined, range_ok reflects a
// real range check; otherwise it is tied high and the immediate is simply
// truncated to its field.
module insn_field_pack
  import arm_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  input  logic [1:0]  hw,
  output logic [31:0] word,
  output logic        legal,
  output logic        range_ok
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_AND:  word = {OPC_AND, rm, 6'd0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'd0, rn, rd};
      OP_ADD:  word = {OPC_ADD, rm, 6'd0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'd0, rn, rd};
      OP_ADDI: word = {OPC_ADDI, imm[11:0], rn, rd};
      OP_SUBI: word = {OPC_SUBI, imm[11:0], rn, rd};
      OP_MOVZ: word = {OPC_MOVZ, hw, imm[15:0], rd};
      OP_B:    word = {OPC_B, imm};
      OP_CBZ:  word = {OPC_CBZ, imm[18:0], rd};
      OP_LDUR: word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STUR: word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      default: legal = 1'b0;
    endcase
  end

`ifdef INSN_ENCODER_RANGECHK_EN
  // Unsigned fields need all upper bits clear; signed fields need the bits
  // above the field to be copies of the field's sign bit.
  always_comb begin
    range_ok = 1'b1;
    case (op)
      OP_ADDI, OP_SUBI: range_ok = ~|imm[25:12];
      OP_MOVZ:          range_ok = ~|imm[25:16];
      OP_LDUR, OP_STUR: range_ok = (&imm[25:8]) | (~|imm[25:8]);
      OP_CBZ:           range_ok = (&imm[25:18]) | (~|imm[25:18]);
      default:          range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: accepts encode requests, packs them into instruction words
// and writes them to instruction memory at an auto-incrementing pointer.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (drops any pending write)
//   bus  - insn_encoder_if.slave (request, pointer load, memory write port,
//          err pulse, acknowledged-write count)
// Parameter ADDR_W: width of imem_addr, base_addr and count.
// Build option INSN_ENCODER_RANGECHK_EN: reject out-of-range immediates
// (handled inside insn_field_pack).
module insn_encoder
  import arm_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input logic           clk,
  input logic           rst,
  insn_encoder_if.slave bus
);

  state_e            state_p1, state_nxt;
  logic [31:0]       word;
  logic              legal, range_ok;
  logic              ready, accept, take, reject;
  logic [31:0]       wdata_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] count_p1;
  logic              err_p1;

  insn_field_pack u_pack (
    .op       (bus.req_op),
    .rd       (bus.req_rd),
    .rn       (bus.req_rn),
    .rm       (bus.req_rm),
    .imm      (bus.req_imm),
    .hw       (bus.req_hw),
    .word     (word),
    .legal    (legal),
    .range_ok (range_ok)
  );

  // Rejected requests still complete the handshake; they only pulse err.
  always_comb begin
    state_nxt = state_p1;
    ready     = (state_p1 == ST_IDLE) && !bus.base_load;
    accept    = bus.req_valid && ready;
    take      = accept && legal && range_ok;
    reject    = accept && !(legal && range_ok);
    case (state_p1)
      ST_IDLE:  if (take) state_nxt = ST_WRITE;
      ST_WRITE: if (bus.imem_ack) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p1: FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= ST_IDLE;
    else     state_p1 <= state_nxt;
  end

  // ---- stage p1: write word, pointer, counter, err ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_p1 <= '0;
      addr_p1  <= '0;
      count_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      err_p1 <= reject;
      if (take) wdata_p1 <= word;
      // A pointer load only matters in IDLE; in WRITE the pointer is frozen
      // until the ack so the presented address stays stable.
      if (state_p1 == ST_IDLE && bus.base_load) begin
        addr_p1 <= bus.base_addr;
      end else if (state_p1 == ST_WRITE && bus.imem_ack) begin
        addr_p1  <= addr_p1 + ADDR_W'(4);
        count_p1 <= count_p1 + ADDR_W'(1);
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.imem_we    = (state_p1 == ST_WRITE);
  assign bus.imem_addr  = addr_p1;
  assign bus.imem_wdata = wdata_p1;
  assign bus.err        = err_p1;
  assign bus.count      = count_p1;

endmodule

// File: tb/tb_insn_encoder.sv
// Testbench for insn_encoder. Expected writes are queued when a request is
// driven and popped when the DUT presents the write. Honors the build option
// INSN_ENCODER_RANGECHK_EN for the out-of-range immediate scenario.
module tb_insn_encoder;
  import arm_pkg::*;

  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  insn_encoder_if #(.ADDR_W(AW)) bus ();
  insn_encoder #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic [1:0]  hw;
    logic [31:0] word;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_count;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_rd    = 5'd0;
    bus.req_rn    = 5'd0;
    bus.req_rm    = 5'd0;
    bus.req_imm   = 26'd0;
    bus.req_hw    = 2'd0;
    bus.base_load = 1'b0;
    bus.base_addr = '0;
    bus.imem_ack  = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw);
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rn    = rn;
    bus.req_rm    = rm;
    bus.req_imm   = imm;
    bus.req_hw    = hw;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // One request through to its ack; stall = cycles with imem_ack low,
  // poke_base = pulse base_load during the stall (must be ignored).
  task automatic send_and_ack(input string name, input logic [3:0] op, input logic [4:0] rd,
                              input logic [4:0] rn, input logic [4:0] rm, input logic [25:0] imm,
                              input logic [1:0] hw, input logic [31:0] exp_word,
                              input int stall, input bit poke_base);
    exp_t e;
    bit seen;
    logic [AW-1:0] a0;
    logic [31:0] w0;
    e.addr = m_addr;
    e.word = exp_word;
    exp_q.push_back(e);
    drive_req(op, rd, rn, rm, imm, hw);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s imem_we never rose within 10 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      a0 = bus.imem_addr;
      w0 = bus.imem_wdata;
      for (int i = 0; i < stall; i++) begin
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== a0 || bus.imem_wdata !== w0 ||
            bus.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_stall%0d we=%b addr=%h wdata=%h ready=%b, required we=1 addr=%h wdata=%h ready=0",
                   name, i, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.req_ready, a0, w0);
        end
        bus.base_load = poke_base;
        bus.base_addr = 64'hDEAD_0000;
        tick();
      end
      bus.base_load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.word) begin
        errors++;
        $display("FAIL %s_write addr=%h wdata=%h, required addr=%h wdata=%h",
                 name, bus.imem_addr, bus.imem_wdata, e.addr, e.word);
      end
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      m_addr  = m_addr + 64'd4;
      m_count = m_count + 64'd1;
      checks++;
      if (bus.imem_we !== 1'b0 || bus.imem_addr !== m_addr || bus.count !== m_count) begin
        errors++;
        $display("FAIL %s_after_ack we=%b addr=%h count=%0d, required we=0 addr=%h count=%0d",
                 name, bus.imem_we, bus.imem_addr, bus.count, m_addr, m_count);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_addr  = '0;
    m_count = '0;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl we=%b err=%b, required 0 0", bus.imem_we, bus.err);
    end
    checks++;
    if (bus.imem_addr !== 64'd0 || bus.count !== 64'd0 || bus.imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data addr=%h count=%0d wdata=%h, required 0", bus.imem_addr, bus.count, bus.imem_wdata);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_add();
    send_and_ack("add", OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 32'h8B020023, 0, 1'b0);
  endtask

  task automatic test_ldur();
    send_and_ack("ldur", OP_LDUR, 5'd5, 5'd2, 5'd0, 26'h3FFFFF8, 2'd0, 32'hF85F8045, 0, 1'b0);
  endtask

  task automatic test_base_b();
    // base_load wins over a simultaneous request
    bus.base_load = 1'b1;
    bus.base_addr = 64'h100;
    bus.req_op    = OP_ADD;
    bus.req_valid = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL base_prio_ready got %b required 0", bus.req_ready);
    end
    tick();
    bus.base_load = 1'b0;
    bus.req_valid = 1'b0;
    m_addr = 64'h100;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.imem_addr !== 64'h100 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL base_load we=%b addr=%h err=%b, required we=0 addr=100 err=0",
               bus.imem_we, bus.imem_addr, bus.err);
    end
    send_and_ack("b_neg1", OP_B, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 32'h17FFFFFF, 0, 1'b0);
  endtask

  task automatic test_stall();
    send_and_ack("stall", OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 32'h8B020023, 5, 1'b1);
  endtask

  task automatic test_formats();
    vec_t v[8];
    v[0] = '{OP_AND,  5'd31, 5'd30, 5'd29, 26'd0,       2'd0, 32'h8A1D03DF};
    v[1] = '{OP_ORR,  5'd6,  5'd5,  5'd4,  26'd0,       2'd0, {11'b10101010000, 5'd4, 6'd0, 5'd5, 5'd6}};
    v[2] = '{OP_SUB,  5'd0,  5'd0,  5'd31, 26'd0,       2'd0, {11'b11001011000, 5'd31, 6'd0, 5'd0, 5'd0}};
    v[3] = '{OP_ADDI, 5'd1,  5'd2,  5'd0,  26'd4095,    2'd0, {10'b1001000100, 12'hFFF, 5'd2, 5'd1}};
    v[4] = '{OP_SUBI, 5'd7,  5'd8,  5'd0,  26'h123,     2'd0, {10'b1101000100, 12'h123, 5'd8, 5'd7}};
    v[5] = '{OP_MOVZ, 5'd9,  5'd17, 5'd18, 26'hBEEF,    2'd2, {9'b110100101, 2'd2, 16'hBEEF, 5'd9}};
    v[6] = '{OP_CBZ,  5'd4,  5'd0,  5'd0,  26'h3FC0000, 2'd0, {8'b10110100, 19'h40000, 5'd4}};
    v[7] = '{OP_STUR, 5'd10, 5'd11, 5'd0,  26'd255,     2'd0, {11'b11111000000, 9'h0FF, 2'b00, 5'd11, 5'd10}};
    for (int i = 0; i < 8; i++) begin
      send_and_ack($sformatf("fmt%0d", i), v[i].op, v[i].rd, v[i].rn, v[i].rm, v[i].imm, v[i].hw,
                   v[i].word, i % 3, 1'b0);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad[2];
    bad[0] = 4'd11;
    bad[1] = 4'd15;
    for (int i = 0; i < 2; i++) begin
      bus.req_op    = bad[i];
      bus.req_valid = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal%0d_ready got %b required 1", i, bus.req_ready);
      end
      tick();
      bus.req_valid = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.imem_we !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_err err=%b we=%b, required err=1 we=0", i, bus.err, bus.imem_we);
      end
      tick();
      checks++;
      if (bus.err !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== m_addr || bus.count !== m_count) begin
        errors++;
        $display("FAIL illegal%0d_after err=%b we=%b addr=%h count=%0d, required err=0 we=0 addr=%h count=%0d",
                 i, bus.err, bus.imem_we, bus.imem_addr, bus.count, m_addr, m_count);
      end
    end
  endtask

  task automatic test_range();
`ifdef INSN_ENCODER_RANGECHK_EN
    logic [3:0]  ops[2];
    logic [25:0] imms[2];
    ops[0] = OP_ADDI; imms[0] = 26'd4096;
    ops[1] = OP_LDUR; imms[1] = 26'h3FFFEFF;
    for (int i = 0; i < 2; i++) begin
      drive_req(ops[i], 5'd1, 5'd2, 5'd0, imms[i], 2'd0);
      checks++;
      if (bus.err !== 1'b1 || bus.imem_we !== 1'b0) begin
        errors++;
        $display("FAIL range%0d_err err=%b we=%b, required err=1 we=0", i, bus.err, bus.imem_we);
      end
      tick();
      checks++;
      if (bus.err !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== m_addr || bus.count !== m_count) begin
        errors++;
        $display("FAIL range%0d_after err=%b we=%b addr=%h count=%0d, required err=0 we=0 addr=%h count=%0d",
                 i, bus.err, bus.imem_we, bus.imem_addr, bus.count, m_addr, m_count);
      end
    end
`else
    send_and_ack("addi_trunc", OP_ADDI, 5'd1, 5'd2, 5'd0, 26'd4096, 2'd0,
                 {10'b1001000100, 12'd0, 5'd2, 5'd1}, 0, 1'b0);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL addi_trunc_err got %b required 0", bus.err);
    end
`endif
  endtask

  task automatic test_ack_idle();
    bus.imem_ack = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.imem_addr !== m_addr || bus.count !== m_count) begin
      errors++;
      $display("FAIL ack_idle we=%b addr=%h count=%0d, required we=0 addr=%h count=%0d",
               bus.imem_we, bus.imem_addr, bus.count, m_addr, m_count);
    end
  endtask

  task automatic test_wrap();
    bus.base_load = 1'b1;
    bus.base_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.base_load = 1'b0;
    m_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    send_and_ack("wrap", OP_ORR, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0,
                 {11'b10101010000, 5'd1, 6'd0, 5'd1, 5'd1}, 1, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    drive_req(OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_addr  = '0;
    m_count = '0;
    exp_q.delete();
    checks++;
    if (bus.imem_we !== 1'b0 || bus.imem_addr !== 64'd0 || bus.count !== 64'd0 ||
        bus.imem_wdata !== 32'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write we=%b addr=%h count=%0d wdata=%h err=%b, required all 0",
               bus.imem_we, bus.imem_addr, bus.count, bus.imem_wdata, bus.err);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_write_ready got %b required 1", bus.req_ready);
    end
    send_and_ack("post_reset", OP_SUB, 5'd2, 5'd3, 5'd4, 26'd0, 2'd0,
                 {11'b11001011000, 5'd4, 6'd0, 5'd3, 5'd2}, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldur();
    test_base_b();
    test_stall();
    test_formats();
    test_illegal();
    test_range();
    test_ack_idle();
    test_wrap();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
